// File: rtl/delay_pipe_pkg.sv
// delay_pipe_pkg: shared defaults and width helpers for the delay_pipe slice
// Exports: WIDTH_DEF/DEPTH_DEF/LANES_DEF, word_def_t, occ_w(), word_w()
package delay_pipe_pkg;
    localparam int WIDTH_DEF = 1;
    localparam int DEPTH_DEF = 3;
    localparam int LANES_DEF = 1;
    typedef logic [LANES_DEF*WIDTH_DEF-1:0] word_def_t;
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int word_w(input int width, input int lanes);
        return width * lanes;
    endfunction
endpackage

// File: rtl/delay_pipe_if.sv
// delay_pipe_if: bundles the delay_pipe data path, control and status signals
// master: drives in_valid/in_data/stall/flush, observes in_ready/out_valid/out_data/occupancy
// slave : the pipe itself, the mirror image of master
interface delay_pipe_if
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LANES = LANES_DEF
);
    logic                     in_valid;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     in_ready;
    logic                     stall;
    logic                     flush;
    logic                     out_valid;
    logic [LANES*WIDTH-1:0]   out_data;
    logic [occ_w(DEPTH)-1:0]  occupancy;
    modport master (output in_valid, in_data, stall, flush,
                    input  in_ready, out_valid, out_data, occupancy);
    modport slave  (input  in_valid, in_data, stall, flush,
                    output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/delay_pipe_stage.sv
// delay_pipe_stage: one valid+data register of the delay line
// Ports: clk, rst_n (async active-low), stall_i (hold), flush_i (clear, beats stall),
//        valid_i/data_i from previous stage, valid_o/data_o to next stage
module delay_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    // Data is zeroed whenever valid is low so empty stages never carry stale words.
    always_comb begin
        valid_d = flush_i ? 1'b0 : stall_i ? valid_q : valid_i;
        data_d  = flush_i ? '0 : stall_i ? data_q : valid_i ? data_i : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/delay_pipe.sv
// delay_pipe: LANES x WIDTH registered delay line of DEPTH stages with stall, flush and occupancy
// Ports: clk, rst_n (async active-low), bus (delay_pipe_if.slave: in_valid/in_data/in_ready,
//        stall, flush, out_valid/out_data, occupancy)
// Build option: DELAY_PIPE_SVA_EN embeds latency/occupancy/data-invariant assertions.
module delay_pipe
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LANES = LANES_DEF
) (
    input logic          clk,
    input logic          rst_n,
    delay_pipe_if.slave  bus
);
    localparam int LW = word_w(WIDTH, LANES);
    localparam int OW = occ_w(DEPTH);
    logic [DEPTH:0]         vld;
    logic [DEPTH:0][LW-1:0] dat;
    logic [OW-1:0]          occ_q, occ_d;
    assign vld[0] = bus.in_valid;
    assign dat[0] = bus.in_data;
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        delay_pipe_stage #(.W(LW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall_i (bus.stall),
            .flush_i (bus.flush),
            .valid_i (vld[i]),
            .data_i  (dat[i]),
            .valid_o (vld[i+1]),
            .data_o  (dat[i+1])
        );
    end
    // Tracked incrementally; cannot overflow since a full pipe always drops a word when it accepts one.
    always_comb occ_d = bus.flush ? '0 : bus.stall ? occ_q : occ_q + OW'(bus.in_valid) - OW'(vld[DEPTH]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end
    assign bus.in_ready  = rst_n && !bus.stall;
    assign bus.out_valid = vld[DEPTH];
    assign bus.out_data  = dat[DEPTH];
    assign bus.occupancy = occ_q;
`ifdef DELAY_PIPE_SVA_EN
    // adv_q[j] remembers whether the pipe advanced j+1 edges ago; only the
    // DEPTH-1 edges after acceptance matter for the latency check.
    localparam logic [DEPTH-1:0] ADV_MASK = DEPTH'((64'd1 << (DEPTH - 1)) - 64'd1);
    logic             adv;
    logic [DEPTH-1:0] adv_q;
    logic             clean;
    assign adv   = !bus.stall && !bus.flush;
    assign clean = &(adv_q | ~ADV_MASK);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) adv_q <= '0;
        else        adv_q <= DEPTH'({adv_q, adv});
    end
    a_latency: assert property (@(posedge clk) disable iff (!rst_n)
        $past(bus.in_valid && bus.in_ready && adv, DEPTH) && clean
        |-> bus.out_valid && bus.out_data == $past(bus.in_data, DEPTH));
    a_occ_pop: assert property (@(posedge clk) disable iff (!rst_n)
        bus.occupancy == OW'($countones(vld[DEPTH:1])));
    a_zero_data: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.out_valid |-> bus.out_data == '0);
    a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
        bus.occupancy <= OW'(DEPTH));
    a_flush: assert property (@(posedge clk) disable iff (!rst_n)
        bus.flush |=> bus.occupancy == '0 && !bus.out_valid);
`endif
endmodule
